// File: rtl/rand_range.sv
// -----------------------------------------------------------------------------
// rand_range
//
// Bounded random-number stage. On a request it draws 16-bit words from a
// free-running generator, masks each word to the smallest power-of-two span
// covering [0, limit), and rejection-samples until a value falls inside the
// range. After MAX_TRIES rejected attempts a deterministic fallback folds the
// last candidate into range, so worst-case latency is bounded. With NO_REPEAT
// set, a result equal to the previous one is rejected (except for limit 1).
//
// Parameters:
//   MAX_TRIES  maximum sampling attempts per request (1..15)
//   NO_REPEAT  1: suppress back-to-back identical results
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst_n   in   1   asynchronous active-low reset
//   rnd_in  in  16   generator word, fresh every cycle
//   req     in   1   request strobe, sampled only while ready=1
//   limit   in  16   exclusive upper bound (0 = full 65536 range)
//   ready   out  1   block is idle and will accept req
//   valid   out  1   one-cycle pulse: value/tries are new
//   value   out 16   result, held until the next valid
//   tries   out  4   attempts used for the current value
// -----------------------------------------------------------------------------
module rand_range #(
  parameter int unsigned MAX_TRIES = 8,
  parameter bit          NO_REPEAT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rnd_in,
  input  logic        req,
  input  logic [15:0] limit,
  output logic        ready,
  output logic        valid,
  output logic [15:0] value,
  output logic [3:0]  tries
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX_TRIES = 4'(MAX_TRIES);

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_lim;
  logic [15:0] r_mask;
  logic [3:0]  r_cnt;
  logic [15:0] r_value;
  logic [3:0]  r_tries;
  logic [15:0] r_last;
  logic        r_last_valid;

  logic [15:0] w_cand;
  logic [3:0]  w_attempt;
  logic        w_in_range;
  logic        w_repeat;
  logic        w_accept;
  logic        w_last_try;
  logic [15:0] w_fold;
  logic [15:0] w_fold_inc;
  logic        w_fold_repeat;
  logic [15:0] w_fallback;
  logic        w_start;
  logic        w_finish;

  // Smear the highest set bit downward: all ones from bit 0 up to the MSB of x.
  function automatic logic [15:0] span_mask(input logic [15:0] x);
    logic [15:0] m;
    m = x;
    for (int s = 1; s < 16; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Candidate evaluation for the current attempt
  // ---------------------------------------------------------------------------
  assign w_cand     = rnd_in & r_mask;
  assign w_attempt  = r_cnt + 4'd1;
  assign w_last_try = (w_attempt == LP_MAX_TRIES);

  // r_lim == 0 encodes the full 65536 range, where every candidate fits.
  assign w_in_range = (r_lim == 16'd0) || (w_cand < r_lim);
  assign w_repeat   = NO_REPEAT && r_last_valid && (w_cand == r_last) &&
                      (r_lim != 16'd1);
  assign w_accept   = w_in_range && !w_repeat;

  // Fallback: the mask never exceeds 2*limit-1, so one subtraction folds the
  // candidate into range. A collision with the last result is bumped by one,
  // wrapping at the limit (the 16-bit add wraps naturally for the full range).
  assign w_fold        = w_in_range ? w_cand : (w_cand - r_lim);
  assign w_fold_inc    = w_fold + 16'd1;
  assign w_fold_repeat = NO_REPEAT && r_last_valid && (r_lim != 16'd1) &&
                         (w_fold == r_last);
  assign w_fallback    = !w_fold_repeat                                ? w_fold     :
                         ((r_lim != 16'd0) && (w_fold_inc == r_lim))   ? 16'd0      :
                                                                         w_fold_inc;

  assign w_start  = (r_state == ST_IDLE) && req;
  assign w_finish = (r_state == ST_SAMPLE) && (w_accept || w_last_try);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: the asynchronous reset sits in the sensitivity list so the block
  // returns to IDLE immediately, even with the clock stopped mid-request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment up front keeps every path driven, so no
  // latch is inferred when a case arm does not change state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (req)      w_state_next = ST_SAMPLE;
      ST_SAMPLE: if (w_finish) w_state_next = ST_DONE;
      ST_DONE:                 w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout, so every register here samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lim        <= 16'd0;
      r_mask       <= 16'd0;
      r_cnt        <= 4'd0;
      r_value      <= 16'd0;
      r_tries      <= 4'd0;
      r_last       <= 16'd0;
      r_last_valid <= 1'b0;
    end else begin
      if (w_start) begin
        r_lim  <= limit;
        // limit 0 wraps to 0xFFFF here, which is exactly the full-range mask.
        r_mask <= span_mask(limit - 16'd1);
        r_cnt  <= 4'd0;
      end

      if (r_state == ST_SAMPLE) begin
        r_cnt <= w_attempt;
      end

      if (w_finish) begin
        r_value <= w_accept ? w_cand : w_fallback;
        r_tries <= w_attempt;
      end

      if (r_state == ST_DONE) begin
        r_last       <= r_value;
        r_last_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready = (r_state == ST_IDLE);
  assign valid = (r_state == ST_DONE);
  assign value = r_value;
  assign tries = r_tries;

endmodule

// File: tb/tb_rand_range.sv
// -----------------------------------------------------------------------------
// tb_rand_range
//
// Self-checking bench for rand_range. Two instances run side by side: dut0 with
// NO_REPEAT=0 and dut1 with NO_REPEAT=1. A driver issues requests and feeds a
// chosen word per attempt; a reference model derives the expected value, the
// attempt count and the cycle of the valid pulse from those words and pushes
// them into a per-instance queue. A monitor on the falling edge pops and
// compares whenever valid is seen, and otherwise checks that value/tries hold.
// -----------------------------------------------------------------------------
module tb_rand_range;

  localparam int MAXT = 8;

  typedef logic [15:0] words_t [MAXT];

  typedef struct {
    logic [15:0] value;
    logic [3:0]  tries;
    int          cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [2];
  logic [15:0] limit  [2];
  logic [15:0] rnd    [2];
  logic        ready  [2];
  logic        valid  [2];
  logic [15:0] value  [2];
  logic [3:0]  tries  [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  exp_t        sb0[$];
  exp_t        sb1[$];
  exp_t        mon_e;
  logic [15:0] m_last [2];
  bit          m_lv   [2];
  logic [15:0] held_v [2];
  logic [3:0]  held_t [2];

  rand_range #(.MAX_TRIES(MAXT), .NO_REPEAT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rnd_in(rnd[0]), .req(req[0]), .limit(limit[0]),
    .ready(ready[0]), .valid(valid[0]), .value(value[0]), .tries(tries[0])
  );

  rand_range #(.MAX_TRIES(MAXT), .NO_REPEAT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rnd_in(rnd[1]), .req(req[1]), .limit(limit[1]),
    .ready(ready[1]), .valid(valid[1]), .value(value[1]), .tries(tries[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the range has `span` values; words are reduced modulo the
  // smallest power of two >= span, accepted if below span and not a forbidden
  // repeat. If every attempt fails, the last reduced word is taken modulo span
  // and stepped forward by one (mod span) if it still repeats.
  task automatic model(input int d, input logic [15:0] lim, input words_t w,
                       output logic [15:0] v, output int k);
    int span;
    int p;
    int c;
    int f;
    bit nr;
    bit guard;
    span  = (lim == 16'd0) ? 65536 : int'(lim);
    p     = 1;
    while (p < span) p = p * 2;
    nr    = (d == 1);
    guard = nr && m_lv[d] && (span != 1);
    v     = 16'd0;
    k     = MAXT;
    for (int a = 1; a <= MAXT; a++) begin
      c = int'(w[a-1]) % p;
      if ((c < span) && !(guard && (c == int'(m_last[d])))) begin
        v = 16'(c);
        k = a;
        break;
      end
      if (a == MAXT) begin
        f = c % span;
        if (guard && (f == int'(m_last[d]))) f = (f + 1) % span;
        v = 16'(f);
        k = a;
      end
    end
    m_last[d] = v;
    m_lv[d]   = 1'b1;
  endtask

  function automatic words_t all_of(input logic [15:0] x);
    words_t w;
    for (int i = 0; i < MAXT; i++) w[i] = x;
    return w;
  endfunction

  function automatic words_t rand_words();
    words_t w;
    for (int i = 0; i < MAXT; i++) begin
      w[i] = 16'($urandom);
      if ($urandom_range(1) == 0) w[i] = w[i] & 16'h001F;
    end
    return w;
  endfunction

  // Issue one request to instance d and feed w[j] as the word for attempt j+1.
  // With stray set, req is also held high while the instance is busy.
  task automatic issue(input int d, input logic [15:0] lim, input words_t w,
                       input bit stray);
    logic [15:0] v;
    int          k;
    int          waited;
    exp_t        e;
    waited = 0;
    @(negedge clk);
    while (!ready[d] && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("dut%0d ready_before_req", d), 32'(ready[d]), 32'd1);
    if (!ready[d]) return;
    model(d, lim, w, v, k);
    e.value = v;
    e.tries = 4'(k);
    e.cycle = cyc + 1 + k;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    req[d]   = 1'b1;
    limit[d] = lim;
    rnd[d]   = 16'($urandom);
    for (int j = 0; j < MAXT; j++) begin
      @(negedge clk);
      if (j == 0) check($sformatf("dut%0d ready_low_busy", d), 32'(ready[d]), 32'd0);
      rnd[d]   = w[j];
      limit[d] = 16'($urandom);
      req[d]   = (stray && j <= k) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  // Monitor: compare on every valid pulse, otherwise require held outputs.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        held_v[d] = 16'd0;
        held_t[d] = 4'd0;
      end else if (valid[d]) begin
        if ((d == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
          n_checks++;
          n_errors++;
          $display("FAIL dut%0d unexpected_valid: got value 0x%0h, expected no valid",
                   d, value[d]);
        end else begin
          mon_e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
          check($sformatf("dut%0d value", d), 32'(value[d]), 32'(mon_e.value));
          check($sformatf("dut%0d tries", d), 32'(tries[d]), 32'(mon_e.tries));
          check($sformatf("dut%0d valid_cycle", d), 32'(cyc), 32'(mon_e.cycle));
          held_v[d] = mon_e.value;
          held_t[d] = mon_e.tries;
        end
      end else begin
        check($sformatf("dut%0d value_hold", d), 32'(value[d]), 32'(held_v[d]));
        check($sformatf("dut%0d tries_hold", d), 32'(tries[d]), 32'(held_t[d]));
      end
    end
  end

  initial begin
    words_t      w;
    int          d;
    int          sel;
    logic [15:0] lim;
    int          waited;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i]    = 1'b0;
      limit[i]  = 16'd0;
      rnd[i]    = 16'd0;
      m_last[i] = 16'd0;
      m_lv[i]   = 1'b0;
      held_v[i] = 16'd0;
      held_t[i] = 4'd0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d reset_ready", i), 32'(ready[i]), 32'd1);
      check($sformatf("dut%0d reset_valid", i), 32'(valid[i]), 32'd0);
      check($sformatf("dut%0d reset_value", i), 32'(value[i]), 32'd0);
      check($sformatf("dut%0d reset_tries", i), 32'(tries[i]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    issue(0, 16'd6, all_of(16'h0003), 1'b0);            // 3, 1 try
    w = all_of(16'h1234); w[0] = 16'hFFFF; w[1] = 16'h000E;
    issue(0, 16'd6, w, 1'b0);                           // 4, 3 tries
    issue(0, 16'd6, all_of(16'h0007), 1'b1);            // fallback 1, 8 tries
    issue(1, 16'd4, all_of(16'h0002), 1'b0);            // 2, 1 try
    issue(1, 16'd4, all_of(16'h0002), 1'b0);            // collision -> 3, 8 tries
    issue(0, 16'd0, all_of(16'hBEEF), 1'b0);            // full range
    issue(1, 16'd1, rand_words(), 1'b0);                // 0, 1 try
    issue(1, 16'd1, rand_words(), 1'b0);                // 0 again, no reject
    w = all_of(16'h0005); w[0] = 16'h8001;
    issue(0, 16'h8001, w, 1'b0);                        // 5, 2 tries

    // Randomized requests.
    for (int n = 0; n < 60; n++) begin
      d   = int'($urandom_range(1));
      sel = int'($urandom_range(3));
      case (sel)
        0:       lim = 16'($urandom_range(16, 1));
        1:       lim = 16'd0;
        2:       lim = 16'($urandom);
        default: lim = 16'((1 << $urandom_range(15)) + 1);
      endcase
      issue(d, lim, rand_words(), bit'($urandom_range(1)));
    end

    // Reset in the middle of a request on both instances.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1; limit[i] = 16'd6; rnd[i] = 16'h0007;
    end
    @(negedge clk);
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d midreset_ready", i), 32'(ready[i]), 32'd1);
      check($sformatf("dut%0d midreset_valid", i), 32'(valid[i]), 32'd0);
      check($sformatf("dut%0d midreset_value", i), 32'(value[i]), 32'd0);
      check($sformatf("dut%0d midreset_tries", i), 32'(tries[i]), 32'd0);
      m_last[i] = 16'd0;
      m_lv[i]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1, 16'd4, all_of(16'h0000), 1'b0);            // 0 accepted first try
    issue(0, 16'd6, all_of(16'h0003), 1'b0);

    // Drain outstanding expectations.
    waited = 0;
    while ((sb0.size() + sb1.size()) != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
